// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_ctrl_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Next channel in scan order; the select wraps from 15 back to 0.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return ch + {{(SEL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: walks the 16:1 selector through a channel range,
// samples the mux output after SETTLE cycles per channel, and presents
// the assembled result/mask word on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; result/mask from the last scan are held
// SCAN  | stepping mux_sel, sampling each channel after the settle time
// DONE  | result_valid high, holding everything until result_ready
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] first_ch,
    input  logic [SEL_W-1:0] last_ch,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             busy,
    output logic [N_CH-1:0]  result,
    output logic [N_CH-1:0]  mask,
    output logic             result_valid,
    input  logic             result_ready
);

    // Terminal count of the settle counter; the sample lands on this count.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    scan_state_e      state_q,   state_d;
    logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
    logic [SEL_W-1:0] last_q,    last_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [N_CH-1:0]  result_q,  result_d;
    logic [N_CH-1:0]  mask_q,    mask_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        mask_d    = mask_q;
        valid_d   = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_d    = last_ch;
                    mux_sel_d = first_ch;
                    result_d  = '0;
                    mask_d    = '0;
                    cnt_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    result_d[mux_sel_q] = mux_out;
                    mask_d[mux_sel_q]   = 1'b1;
                    cnt_d               = '0;
                    if (mux_sel_q == last_q) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        mux_sel_d = next_ch(mux_sel_q);
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the
                // handshake cycle, so a request never queues behind a result.
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronous reset abandons any scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mux_sel_q <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            mask_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign mux_sel      = mux_sel_q;
    assign result       = result_q;
    assign mask         = mask_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3), each
// driving a behavioural 16:1 selector mux, checked every cycle against a
// scan-position model plus literal expectations.
module tb_mux_scan_ctrl;
    import mux_scan_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i [2];
    logic [3:0]  first_i [2];
    logic [3:0]  last_i  [2];
    logic [15:0] data_i  [2];
    logic        ready_i [2];
    logic [3:0]  sel_o   [2];
    logic        mux_o   [2];
    logic        busy_o  [2];
    logic [15:0] res_o   [2];
    logic [15:0] mask_o  [2];
    logic        valid_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Behavioural 16:1 selector muxes feeding mux_out.
    assign mux_o[0] = data_i[0][sel_o[0]];
    assign mux_o[1] = data_i[1][sel_o[1]];

    mux_scan_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]),
        .first_ch(first_i[0]), .last_ch(last_i[0]),
        .mux_sel(sel_o[0]), .mux_out(mux_o[0]), .busy(busy_o[0]),
        .result(res_o[0]), .mask(mask_o[0]),
        .result_valid(valid_o[0]), .result_ready(ready_i[0])
    );

    mux_scan_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]),
        .first_ch(first_i[1]), .last_ch(last_i[1]),
        .mux_sel(sel_o[1]), .mux_out(mux_o[1]), .busy(busy_o[1]),
        .result(res_o[1]), .mask(mask_o[1]),
        .result_valid(valid_o[1]), .result_ready(ready_i[1])
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position k cycles into a scan determines the channel under
    // the select (first + k/SETTLE) and when each sample lands.
    int          m_phase [2];
    int          m_k     [2];
    int          m_first [2];
    int          m_len   [2];
    logic [15:0] m_res   [2];
    logic [15:0] m_mask  [2];
    logic [3:0]  m_sel   [2];
    logic        m_valid [2];

    always @(posedge clk) begin
        int s, k1, idx, ch;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? 1 : 3;
            if (!rst_n) begin
                m_phase[i] <= 0;
                m_sel[i]   <= 4'd0;
                m_res[i]   <= 16'd0;
                m_mask[i]  <= 16'd0;
                m_valid[i] <= 1'b0;
                m_k[i]     <= 0;
            end else if (m_phase[i] == 0) begin
                if (start_i[i]) begin
                    m_first[i] <= int'(first_i[i]);
                    m_len[i]   <= ((int'(last_i[i]) - int'(first_i[i]) + 16) % 16) + 1;
                    m_k[i]     <= 0;
                    m_res[i]   <= 16'd0;
                    m_mask[i]  <= 16'd0;
                    m_sel[i]   <= first_i[i];
                    m_phase[i] <= 1;
                end
            end else if (m_phase[i] == 1) begin
                k1 = m_k[i] + 1;
                m_k[i] <= k1;
                if (k1 % s == 0) begin
                    idx = k1 / s - 1;
                    ch  = (m_first[i] + idx) % 16;
                    m_res[i][ch]  <= data_i[i][ch];
                    m_mask[i][ch] <= 1'b1;
                    if (idx == m_len[i] - 1) begin
                        m_phase[i] <= 2;
                        m_valid[i] <= 1'b1;
                    end else begin
                        m_sel[i] <= 4'((m_first[i] + idx + 1) % 16);
                    end
                end
            end else begin
                if (ready_i[i]) begin
                    m_valid[i] <= 1'b0;
                    m_phase[i] <= 0;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_sel", i),   16'(sel_o[i]),   16'(m_sel[i]));
                chk($sformatf("m%0d_busy", i),  16'(busy_o[i]),  16'(m_phase[i] != 0));
                chk($sformatf("m%0d_res", i),   res_o[i],        m_res[i]);
                chk($sformatf("m%0d_mask", i),  mask_o[i],       m_mask[i]);
                chk($sformatf("m%0d_valid", i), 16'(valid_o[i]), 16'(m_valid[i]));
            end
        end
    end

    // Inputs change #1 after the rising edge throughout.
    task automatic do_start(input int i, input logic [3:0] f, input logic [3:0] l);
        first_i[i] = f;
        last_i[i]  = l;
        start_i[i] = 1'b1;
        @(posedge clk); #1;
        start_i[i] = 1'b0;
    endtask

    // Counts edges after the accept edge until result_valid; optionally
    // pulses start (with a different range) at cycle pulse_at.
    task automatic wait_valid(input int i, input int pulse_at, input string nm, output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            cyc++;
            start_i[i] = 1'b0;
            if (valid_o[i]) begin
                ok = 1'b1;
                break;
            end
            if (cyc == pulse_at) begin
                first_i[i] = 4'd9;
                last_i[i]  = 4'd9;
                start_i[i] = 1'b1;
            end
        end
        chk({nm, "_valid_seen"}, 16'(ok), 16'd1);
    endtask

    task automatic handshake(input int i, input string nm);
        ready_i[i] = 1'b1;
        @(posedge clk); #1;
        ready_i[i] = 1'b0;
        chk({nm, "_hs_valid"}, 16'(valid_o[i]), 16'd0);
        chk({nm, "_hs_busy"},  16'(busy_o[i]),  16'd0);
    endtask

    initial begin
        int cyc;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            first_i[i] = 4'd0;
            last_i[i]  = 4'd0;
            data_i[i]  = 16'd0;
            ready_i[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_sel", i),   16'(sel_o[i]),   16'd0);
            chk($sformatf("rst%0d_res", i),   res_o[i],        16'd0);
            chk($sformatf("rst%0d_mask", i),  mask_o[i],       16'd0);
            chk($sformatf("rst%0d_valid", i), 16'(valid_o[i]), 16'd0);
            chk($sformatf("rst%0d_busy", i),  16'(busy_o[i]),  16'd0);
        end

        // Full scan, SETTLE=1
        data_i[0] = 16'hA5C3;
        do_start(0, 4'd0, 4'd15);
        wait_valid(0, -1, "full", cyc);
        chk("full_lat",  16'(cyc),  16'd16);
        chk("full_res",  res_o[0],  16'hA5C3);
        chk("full_mask", mask_o[0], 16'hFFFF);
        handshake(0, "full");

        // Wrap-around 14,15,0,1
        data_i[0] = 16'hFFFF;
        do_start(0, 4'd14, 4'd1);
        wait_valid(0, -1, "wrap", cyc);
        chk("wrap_lat",  16'(cyc),  16'd4);
        chk("wrap_res",  res_o[0],  16'hC003);
        chk("wrap_mask", mask_o[0], 16'hC003);
        handshake(0, "wrap");

        // Settle timing, SETTLE=3: bit 5 rises during the 2nd cycle at sel 5
        data_i[1] = 16'h0000;
        do_start(1, 4'd0, 4'd15);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 16) begin
                chk("settle_sel_at16", 16'(sel_o[1]), 16'd5);
                data_i[1][5] = 1'b1;
            end
            if (valid_o[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("settle_valid_seen", 16'(ok), 16'd1);
        chk("settle_lat",  16'(cyc),  16'd48);
        chk("settle_res",  res_o[1],  16'h0020);
        chk("settle_mask", mask_o[1], 16'hFFFF);
        handshake(1, "settle");

        // Backpressure and start rejection during SCAN and DONE
        data_i[0] = 16'h1234;
        do_start(0, 4'd3, 4'd6);
        wait_valid(0, 2, "bp", cyc);
        chk("bp_lat",  16'(cyc),  16'd4);
        chk("bp_res",  res_o[0],  16'h0030);
        chk("bp_mask", mask_o[0], 16'h0078);
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                first_i[0] = 4'd9;
                last_i[0]  = 4'd9;
                start_i[0] = 1'b1;
            end
            @(posedge clk); #1;
            start_i[0] = 1'b0;
            chk("bp_hold_res",   res_o[0],        16'h0030);
            chk("bp_hold_mask",  mask_o[0],       16'h0078);
            chk("bp_hold_sel",   16'(sel_o[0]),   16'd6);
            chk("bp_hold_valid", 16'(valid_o[0]), 16'd1);
        end
        start_i[0] = 1'b1;
        ready_i[0] = 1'b1;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        ready_i[0] = 1'b0;
        chk("bp_hs_valid", 16'(valid_o[0]), 16'd0);
        chk("bp_hs_busy",  16'(busy_o[0]),  16'd0);
        @(posedge clk); #1;
        chk("bp_idle_busy", 16'(busy_o[0]), 16'd0);
        chk("bp_idle_res",  res_o[0],       16'h0030);

        // Single channel on both settle settings
        data_i[1] = 16'h0080;
        do_start(1, 4'd7, 4'd7);
        wait_valid(1, -1, "one3", cyc);
        chk("one3_lat",  16'(cyc),  16'd3);
        chk("one3_res",  res_o[1],  16'h0080);
        chk("one3_mask", mask_o[1], 16'h0080);
        handshake(1, "one3");
        data_i[0] = 16'h0080;
        do_start(0, 4'd7, 4'd7);
        wait_valid(0, -1, "one1", cyc);
        chk("one1_lat",  16'(cyc),  16'd1);
        chk("one1_res",  res_o[0],  16'h0080);
        handshake(0, "one1");

        // Reset at channel 9, then a fresh scan
        data_i[0] = 16'hFFFF;
        do_start(0, 4'd0, 4'd15);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sel_o[0] == 4'd9) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rstmid_reach9", 16'(ok), 16'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_sel",   16'(sel_o[0]),   16'd0);
        chk("rstmid_res",   res_o[0],        16'd0);
        chk("rstmid_mask",  mask_o[0],       16'd0);
        chk("rstmid_valid", 16'(valid_o[0]), 16'd0);
        chk("rstmid_busy",  16'(busy_o[0]),  16'd0);
        rst_n = 1'b1;
        data_i[0] = 16'h5A5A;
        do_start(0, 4'd4, 4'd7);
        wait_valid(0, -1, "fresh", cyc);
        chk("fresh_lat",  16'(cyc),  16'd4);
        chk("fresh_res",  res_o[0],  16'h0050);
        chk("fresh_mask", mask_o[0], 16'h00F0);
        handshake(0, "fresh");

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
